// File: rtl/mc_seq_pkg.sv
// Shared encodings for the multi-cycle EX sequencer (mc_seq).
// The divider is present only when MC_SEQ_DIV_EN is defined.
package mc_seq_pkg;

    // op_i encodings
    localparam logic [1:0] MC_OP_NONE = 2'b00;
    localparam logic [1:0] MC_OP_MACC = 2'b01;
    localparam logic [1:0] MC_OP_DIV  = 2'b10;
    localparam logic [1:0] MC_OP_DIVU = 2'b11;

    // One quotient bit per iteration, so this equals the operand width.
    localparam int MC_DIV_ITERS = 32;

    typedef enum logic [1:0] {
        MC_ST_IDLE      = 2'd0,
        MC_ST_MACC_DONE = 2'd1,
        MC_ST_DIV_RUN   = 2'd2,
        MC_ST_DIV_DONE  = 2'd3
    } mc_state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mc_seq_div_step.sv
// One combinational restoring-division iteration for mc_seq.
// {rem,quot} holds the partial remainder and the remaining dividend bits;
// each step shifts one dividend bit into rem and one quotient bit into quot.
// Compiled only when MC_SEQ_DIV_EN is defined.
`ifdef MC_SEQ_DIV_EN
module mc_seq_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quot_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quot_o
);

    logic [32:0] shifted;
    logic [32:0] trial;

    // Trial-subtract the divisor; bit 32 of the difference is the borrow
    // because the shifted remainder is always below twice the divisor.
    always_comb begin
        shifted = {rem_i, quot_i[31]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[32]) begin
            rem_o  = shifted[31:0];
            quot_o = {quot_i[30:0], 1'b0};
        end else begin
            rem_o  = trial[31:0];
            quot_o = {quot_i[30:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/mc_seq.sv
// mc_seq: sequencer for multi-cycle EX ops (MADD/MSUB, DIV/DIVU).
// Configuration macro: MC_SEQ_DIV_EN enables DIV/DIVU; without it those ops
// raise a one-cycle illegal_o and the divider is not built.
//
// Stall interface: stall_req_o is a combinational request that is high in
// the start cycle and every DIV_RUN cycle; it drops in the cycle the result
// is presented (result_valid_o=1). The result stays presented while hold_i
// is high and is retired at the first clock edge with hold_i low. annul_i
// and rst force all requests/pulses low in the cycle they are seen.
module mc_seq
    import mc_seq_pkg::*;
#(
    parameter int DIV_ITERS = MC_DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic        sub_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic [63:0] hilo_cur_i,
    input  logic        hold_i,
    input  logic        annul_i,
    output logic        stall_req_o,
    output logic        result_valid_o,
    output logic [63:0] result_o,
    output logic        busy_o,
    output logic        illegal_o
);

    // The divider walks one quotient bit per cycle over a 32-bit operand.
    if (DIV_ITERS != 32) begin : g_div_iters_chk
        $error("mc_seq: DIV_ITERS must equal the 32-bit operand width");
    end

    mc_state_t   state_q, state_d;
    logic        start_ok;
    logic        op_is_macc;
    logic [63:0] prod_full;
    logic [63:0] prod_q;
    logic        sub_q;
    logic [63:0] macc_sum;

    assign start_ok   = (state_q == MC_ST_IDLE) && start_i && (op_i != MC_OP_NONE) && !annul_i;
    assign op_is_macc = (op_i == MC_OP_MACC);
    // Sign-extended 64x64 multiply truncated to 64 bits is the signed 32x32 product.
    assign prod_full  = {{32{opdata1_i[31]}}, opdata1_i} * {{32{opdata2_i[31]}}, opdata2_i};
    assign macc_sum   = sub_q ? (hilo_cur_i - prod_q) : (hilo_cur_i + prod_q);
    assign busy_o     = (state_q != MC_ST_IDLE);

`ifdef MC_SEQ_DIV_EN
    localparam logic [5:0] CNT_LAST = 6'(DIV_ITERS - 1);

    logic [31:0] rem_q, quot_q, dvsr_q;
    logic        neg_quot_q, neg_rem_q;
    logic [5:0]  cnt_q;
    logic [31:0] step_rem, step_quot;
    logic        op_signed, a_neg, b_neg;

    assign op_signed = (op_i == MC_OP_DIV);
    assign a_neg     = op_signed && opdata1_i[31];
    assign b_neg     = op_signed && opdata2_i[31];

    mc_seq_div_step u_div_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Divider registers: load magnitudes on start, one restoring step per DIV_RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
        end else if (!annul_i) begin
            if (start_ok && !op_is_macc) begin
                if (opdata2_i == 32'd0) begin
                    rem_q      <= opdata1_i;
                    quot_q     <= 32'hFFFF_FFFF;
                    neg_quot_q <= 1'b0;
                    neg_rem_q  <= 1'b0;
                end else begin
                    rem_q      <= '0;
                    quot_q     <= neg_if(opdata1_i, a_neg);
                    dvsr_q     <= neg_if(opdata2_i, b_neg);
                    neg_quot_q <= a_neg ^ b_neg;
                    neg_rem_q  <= a_neg;
                    cnt_q      <= '0;
                end
            end else if (state_q == MC_ST_DIV_RUN) begin
                rem_q  <= step_rem;
                quot_q <= step_quot;
                cnt_q  <= cnt_q + 6'd1;
            end
        end
    end
`endif

    // MACC registers: capture the product and add/sub selection on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            sub_q  <= 1'b0;
        end else if (start_ok && op_is_macc) begin
            prod_q <= prod_full;
            sub_q  <= sub_i;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= MC_ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and outputs; rst/annul_i override everything in the same cycle.
    always_comb begin
        state_d        = state_q;
        stall_req_o    = 1'b0;
        result_valid_o = 1'b0;
        result_o       = '0;
        illegal_o      = 1'b0;
        case (state_q)
            MC_ST_IDLE: begin
                if (start_ok) begin
                    if (op_is_macc) begin
                        stall_req_o = 1'b1;
                        state_d     = MC_ST_MACC_DONE;
                    end else begin
`ifdef MC_SEQ_DIV_EN
                        stall_req_o = 1'b1;
                        state_d     = (opdata2_i == 32'd0) ? MC_ST_DIV_DONE : MC_ST_DIV_RUN;
`else
                        illegal_o   = (op_i == MC_OP_DIV) || (op_i == MC_OP_DIVU);
`endif
                    end
                end
            end
            MC_ST_MACC_DONE: begin
                result_valid_o = 1'b1;
                result_o       = macc_sum;
                if (!hold_i) state_d = MC_ST_IDLE;
            end
`ifdef MC_SEQ_DIV_EN
            MC_ST_DIV_RUN: begin
                stall_req_o = 1'b1;
                if (cnt_q == CNT_LAST) state_d = MC_ST_DIV_DONE;
            end
            MC_ST_DIV_DONE: begin
                result_valid_o = 1'b1;
                result_o       = {neg_if(rem_q, neg_rem_q), neg_if(quot_q, neg_quot_q)};
                if (!hold_i) state_d = MC_ST_IDLE;
            end
`endif
            default: state_d = MC_ST_IDLE;
        endcase
        if (rst || annul_i) begin
            state_d        = MC_ST_IDLE;
            stall_req_o    = 1'b0;
            result_valid_o = 1'b0;
            result_o       = '0;
            illegal_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_seq.sv
// Self-checking bench for mc_seq. Builds with or without MC_SEQ_DIV_EN and
// exercises whichever feature set is compiled in.
module tb_mc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic        sub_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] hilo_cur_i;
    logic        hold_i;
    logic        annul_i;
    logic        stall_req_o;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic        busy_o;
    logic        illegal_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    mc_seq dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .op_i           (op_i),
        .sub_i          (sub_i),
        .opdata1_i      (opdata1_i),
        .opdata2_i      (opdata2_i),
        .hilo_cur_i     (hilo_cur_i),
        .hold_i         (hold_i),
        .annul_i        (annul_i),
        .stall_req_o    (stall_req_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .busy_o         (busy_o),
        .illegal_o      (illegal_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference models ----------------
    function automatic logic [63:0] macc_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [63:0] hilo, input logic sub);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return sub ? (hilo - 64'(p)) : (hilo + 64'(p));
    endfunction

    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic is_signed);
        int q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (is_signed) begin
            q = signed'(a) / signed'(b);
            r = signed'(a) % signed'(b);
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge. Drives one op, pushes its expected result,
    // waits (bounded) for result_valid_o, pops and compares, honours hold_n,
    // then checks the sequencer returns to idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic sub,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo,
                          input int hold_n, input int exp_lat, input logic [63:0] exp_res);
        int cyc;
        int stalls;
        logic [63:0] e;
        exp_q.push_back(exp_res);
        start_i    = 1'b1;
        op_i       = op;
        sub_i      = sub;
        opdata1_i  = a;
        opdata2_i  = b;
        hilo_cur_i = hilo;
        hold_i     = (hold_n > 0);
        #1;
        chk({tag, ".stall_start"}, 64'(stall_req_o), 64'd1);
        cyc    = 0;
        stalls = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!result_valid_o && stall_req_o) stalls++;
        end while (!result_valid_o && cyc < 100);
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, ".stall_cycles"}, 64'(stalls), 64'(exp_lat - 1));
        chk({tag, ".stall_at_valid"}, 64'(stall_req_o), 64'd0);
        e = exp_q.pop_front();
        chk({tag, ".result"}, result_o, e);
        start_i = 1'b0;
        op_i    = 2'b00;
        for (int i = 1; i < hold_n; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(result_valid_o), 64'd1);
            chk({tag, ".hold_result"}, result_o, e);
        end
        hold_i = 1'b0;
        if (!result_valid_o) begin
            annul_i = 1'b1;
            @(negedge clk);
            annul_i = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".idle_after"}, 64'(busy_o), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b;
        logic        s;
        rst        = 1'b1;
        start_i    = 1'b1;
        op_i       = 2'b01;
        sub_i      = 1'b0;
        opdata1_i  = 32'd3;
        opdata2_i  = 32'd4;
        hilo_cur_i = 64'd0;
        hold_i     = 1'b0;
        annul_i    = 1'b0;
        repeat (3) @(negedge clk);
        // reset overrides a pending start
        chk("reset.stall", 64'(stall_req_o), 64'd0);
        chk("reset.valid", 64'(result_valid_o), 64'd0);
        chk("reset.result", result_o, 64'd0);
        chk("reset.busy", 64'(busy_o), 64'd0);
        chk("reset.illegal", 64'(illegal_o), 64'd0);
        start_i = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk("post_reset.busy", 64'(busy_o), 64'd0);

        // directed MACC
        run_op("madd_3x4", 2'b01, 1'b0, 32'd3, 32'd4, 64'h1, 0, 1, 64'hD);
        run_op("msub_2x5", 2'b01, 1'b1, 32'd2, 32'd5, 64'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF6);
        run_op("madd_neg", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0, 3, 1,
               64'h0000_0000_8000_0000);

        // random MACC
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            hilo_cur_i = {$urandom, $urandom};
            run_op("macc_rand", 2'b01, s, a, b, hilo_cur_i, $urandom_range(0, 3), 1,
                   macc_model(a, b, hilo_cur_i, s));
        end

        // annul while the MACC result is presented
        start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd6; opdata2_i = 32'd7;
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("annul_macc.valid", 64'(result_valid_o), 64'd0);
        chk("annul_macc.result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_macc.busy", 64'(busy_o), 64'd0);

        // annul in IDLE blocks a start
        start_i = 1'b1; op_i = 2'b01; annul_i = 1'b1;
        #1;
        chk("annul_idle.stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        chk("annul_idle.busy", 64'(busy_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);

`ifdef MC_SEQ_DIV_EN
        // directed DIV/DIVU
        run_op("div_m7_2", 2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h0, 0, 33,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_100_0", 2'b11, 1'b0, 32'd100, 32'd0, 64'h0, 0, 1,
               {32'd100, 32'hFFFF_FFFF});
        run_op("divu_9_3_hold", 2'b11, 1'b0, 32'd9, 32'd3, 64'h0, 5, 33, {32'd0, 32'd3});
        run_op("div_min_by_1", 2'b10, 1'b0, 32'h8000_0000, 32'd1, 64'h0, 0, 33,
               {32'd0, 32'h8000_0000});

        // random DIV/DIVU
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 50)));
            s = 1'($urandom_range(0, 1));
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_op("div_rand", s ? 2'b10 : 2'b11, 1'b0, a, b, 64'h0, $urandom_range(0, 2),
                   (b == 32'd0) ? 1 : 33, div_model(a, b, s));
        end

        // annul at cycle 10 of DIV_RUN
        start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd7;
        repeat (10) @(negedge clk);
        chk("annul_div.busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("annul_div.stall", 64'(stall_req_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_div.busy", 64'(busy_o), 64'd0);
        // a fresh op after the annul still computes correctly
        run_op("div_after_annul", 2'b10, 1'b0, 32'd1000, 32'd7, 64'h0, 0, 33, {32'd6, 32'd142});
`else
        // DIV/DIVU not built: one-cycle illegal pulse, no stall, stays idle
        for (int k = 0; k < 2; k++) begin
            start_i = 1'b1; op_i = (k == 0) ? 2'b10 : 2'b11; opdata1_i = 32'd9; opdata2_i = 32'd3;
            #1;
            chk("illegal.pulse", 64'(illegal_o), 64'd1);
            chk("illegal.stall", 64'(stall_req_o), 64'd0);
            @(negedge clk);
            chk("illegal.busy", 64'(busy_o), 64'd0);
            chk("illegal.valid", 64'(result_valid_o), 64'd0);
            start_i = 1'b0;
            #1;
            chk("illegal.end", 64'(illegal_o), 64'd0);
            @(negedge clk);
        end
        // annul suppresses the illegal pulse
        start_i = 1'b1; op_i = 2'b10; annul_i = 1'b1;
        #1;
        chk("illegal.annulled", 64'(illegal_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
`endif

        chk("scoreboard.empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
